// File: rtl/tick_ctrl_pkg.sv
// Shared types and constants for the tick-driven operand entry block.
package tick_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HOLD   = 2'd1,
        REPEAT = 2'd2,
        FAST   = 2'd3
    } axis_state_t;

    typedef enum logic [1:0] {
        DIR_NONE = 2'd0,
        DIR_DEC  = 2'd1,
        DIR_INC  = 2'd2
    } axis_dir_t;

    localparam int unsigned STEP_SLOW = 1;
    localparam int unsigned STEP_FAST = 8;

    // Exactly one button pressed gives a direction; both or neither cancel out.
    function automatic axis_dir_t decode_dir(input logic dec, input logic inc);
        axis_dir_t d;
        case ({dec, inc})
            2'b10:   d = DIR_DEC;
            2'b01:   d = DIR_INC;
            default: d = DIR_NONE;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/tick_axis.sv
// One operand axis: button decode, hold/auto-repeat FSM and a saturating or wrapping adder.
module tick_axis
    import tick_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH        = 32,
    parameter int unsigned REPEAT_DELAY = 8,
    parameter int unsigned FAST_AFTER   = 16,
    parameter bit          SATURATE     = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick_cycle,
    input  logic             clear,
    input  logic             dec,
    input  logic             inc,
    output logic [WIDTH-1:0] value,
    output logic             changed_c
);

    localparam int unsigned EW      = WIDTH + 1;
    localparam int unsigned CNT_MAX = (REPEAT_DELAY > FAST_AFTER) ? REPEAT_DELAY : FAST_AFTER;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    axis_state_t      state, state_next;
    axis_dir_t        dir, dir_q, dir_next;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic             step_en, step_fast;
    logic [EW-1:0]    step_amt, sum;
    logic [WIDTH-1:0] value_next;

    // Next-state logic; cnt holds the hold length in HOLD and the repeat count in REPEAT.
    always_comb begin
        state_next = state;
        dir_next   = dir_q;
        cnt_next   = cnt;
        step_en    = 1'b0;
        step_fast  = 1'b0;
        dir        = decode_dir(dec, inc);
        if (tick_cycle) begin
            dir_next = dir;
            if (dir == DIR_NONE) begin
                state_next = IDLE;
                cnt_next   = '0;
            end else if (state == IDLE || dir != dir_q) begin
                step_en    = 1'b1;
                state_next = HOLD;
                cnt_next   = CNT_W'(1);
            end else begin
                case (state)
                    HOLD: begin
                        if (cnt == CNT_W'(REPEAT_DELAY)) begin
                            step_en    = 1'b1;
                            state_next = REPEAT;
                            cnt_next   = CNT_W'(1);
                        end else begin
                            cnt_next = cnt + CNT_W'(1);
                        end
                    end
                    REPEAT: begin
                        step_en = 1'b1;
                        if (cnt == CNT_W'(FAST_AFTER)) begin
                            step_fast  = 1'b1;
                            state_next = FAST;
                        end else begin
                            cnt_next = cnt + CNT_W'(1);
                        end
                    end
                    FAST: begin
                        step_en   = 1'b1;
                        step_fast = 1'b1;
                    end
                    default: state_next = IDLE;
                endcase
            end
        end
        if (clear) begin
            state_next = IDLE;
            dir_next   = DIR_NONE;
            cnt_next   = '0;
            step_en    = 1'b0;
        end
    end

    // Operand adder with a carry/borrow bit used for clamping.
    always_comb begin
        step_amt   = step_fast ? EW'(STEP_FAST) : EW'(STEP_SLOW);
        sum        = '0;
        value_next = value;
        if (clear) begin
            value_next = '0;
        end else if (step_en) begin
            if (dir == DIR_INC) begin
                sum        = {1'b0, value} + step_amt;
                value_next = (SATURATE && sum[WIDTH]) ? '1 : sum[WIDTH-1:0];
            end else begin
                sum        = {1'b0, value} - step_amt;
                value_next = (SATURATE && sum[WIDTH]) ? '0 : sum[WIDTH-1:0];
            end
        end
        changed_c = (value_next != value);
    end

    // Axis state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            dir_q <= DIR_NONE;
            cnt   <= '0;
            value <= '0;
        end else begin
            state <= state_next;
            dir_q <= dir_next;
            cnt   <= cnt_next;
            value <= value_next;
        end
    end

endmodule

// File: rtl/tick_operand_ctrl.sv
// Operand entry for the multiplier demo: two button axes feeding a pipelined full-width multiply.
module tick_operand_ctrl
    import tick_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH        = 32,
    parameter int unsigned MULT_LAT     = 4,
    parameter int unsigned REPEAT_DELAY = 8,
    parameter int unsigned FAST_AFTER   = 16,
    parameter bit          SATURATE     = 1'b0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               tick_cycle,
    input  logic               up,
    input  logic               down,
    input  logic               left,
    input  logic               right,
    input  logic               clear,
    output logic [WIDTH-1:0]   multiplier,
    output logic [WIDTH-1:0]   multiplicand,
    output logic [2*WIDTH-1:0] product,
    output logic               product_valid
);

    localparam int unsigned PW = 2 * WIDTH;
    localparam int unsigned CW = $clog2(MULT_LAT + 1);

    logic          h_changed_c, v_changed_c;
    logic [PW-1:0] pipe [MULT_LAT];
    logic [CW-1:0] chg_cnt, chg_cnt_next;

    tick_axis #(
        .WIDTH(WIDTH), .REPEAT_DELAY(REPEAT_DELAY), .FAST_AFTER(FAST_AFTER), .SATURATE(SATURATE)
    ) u_horiz (
        .clk(clk), .rst(rst), .tick_cycle(tick_cycle), .clear(clear),
        .dec(left), .inc(right), .value(multiplier), .changed_c(h_changed_c)
    );

    tick_axis #(
        .WIDTH(WIDTH), .REPEAT_DELAY(REPEAT_DELAY), .FAST_AFTER(FAST_AFTER), .SATURATE(SATURATE)
    ) u_vert (
        .clk(clk), .rst(rst), .tick_cycle(tick_cycle), .clear(clear),
        .dec(up), .inc(down), .value(multiplicand), .changed_c(v_changed_c)
    );

    // Multiply then delay; synthesis retimes the multiplier across the chain.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(MULT_LAT); i++) pipe[i] <= '0;
        end else begin
            pipe[0] <= PW'(multiplier) * PW'(multiplicand);
            for (int i = 1; i < int'(MULT_LAT); i++) pipe[i] <= pipe[i-1];
        end
    end

    assign product = pipe[MULT_LAT-1];

    // Reload on any operand change, otherwise count down to zero.
    always_comb begin
        chg_cnt_next = chg_cnt;
        if (h_changed_c || v_changed_c) begin
            chg_cnt_next = CW'(MULT_LAT);
        end else if (chg_cnt != '0) begin
            chg_cnt_next = chg_cnt - CW'(1);
        end
    end

    // Valid tracker registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            chg_cnt       <= CW'(MULT_LAT);
            product_valid <= 1'b0;
        end else begin
            chg_cnt       <= chg_cnt_next;
            product_valid <= (chg_cnt_next == '0);
        end
    end

endmodule
